// File: rtl/clock_set_ctrl.sv
// Button sequencer for the alarm clock: set-mode FSM, advance pulses with auto-repeat/timeout, alarm ring FSM.
// Optional snooze support is enabled by defining CLOCK_SET_SNOOZE_EN.
module clock_set_ctrl #(
  parameter int HOLD_CYC    = 2,
  parameter int REPEAT_CYC  = 1,
  parameter int TIMEOUT_CYC = 30,
  parameter int RING_CYC    = 60
`ifdef CLOCK_SET_SNOOZE_EN
  ,
  parameter int SNOOZE_CYC  = 300,
  parameter int MAX_SNOOZE  = 3
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       adv_btn,
  input  logic       snooze_btn,
  input  logic       alarm_on,
  input  logic       alarm_match,
  output logic       timeset,
  output logic       alarmset,
  output logic       min_adv,
  output logic       hrs_adv,
  output logic       day_adv,
  output logic       buzz,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_TMIN = 3'd1,
    SET_THRS = 3'd2,
    SET_DAY  = 3'd3,
    SET_AMIN = 3'd4,
    SET_AHRS = 3'd5
  } set_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1
`ifdef CLOCK_SET_SNOOZE_EN
    ,
    SNOOZE = 2'd2
`endif
  } ring_state_t;

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(REPEAT_CYC + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
`ifdef CLOCK_SET_SNOOZE_EN
  localparam int TMAX = (RING_CYC > SNOOZE_CYC) ? RING_CYC : SNOOZE_CYC;
  localparam int SW   = $clog2(MAX_SNOOZE + 1);
`else
  localparam int TMAX = RING_CYC;
`endif
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [HW-1:0] HOLD_V    = HW'(HOLD_CYC);
  localparam logic [RW-1:0] REPEAT_V  = RW'(REPEAT_CYC);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] RING_LAST = TW'(RING_CYC - 1);
  localparam logic [TW-1:0] TSAT      = TW'(TMAX);
`ifdef CLOCK_SET_SNOOZE_EN
  localparam logic [TW-1:0] SNZ_LAST  = TW'(SNOOZE_CYC - 1);
  localparam logic [SW-1:0] MAX_SNZ_V = SW'(MAX_SNOOZE);
`endif

  logic mode_s, mode_p, adv_s, adv_p, snz_s, snz_p, am_p;
  logic mode_ev, adv_ev, snz_ev, am_edge, activity, in_set;

  set_state_t       set_q, set_d;
  logic [HW-1:0]    hold_cnt;
  logic [RW-1:0]    rpt_cnt;
  logic             rpt_on;
  logic [IW-1:0]    idle_cnt;
  logic             adv_go, fire;

  ring_state_t      ring_q, ring_d;
  logic [TW-1:0]    tmr;
  logic             tmr_load;
`ifdef CLOCK_SET_SNOOZE_EN
  logic [SW-1:0]    snz_cnt;
  logic             snz_clr, snz_inc;
`endif

  assign mode_ev  = mode_s & ~mode_p;
  assign adv_ev   = adv_s & ~adv_p;
  assign snz_ev   = snz_s & ~snz_p;
  assign am_edge  = alarm_match & ~am_p;
  assign activity = mode_ev | adv_ev | adv_s;
  assign in_set   = (set_q != RUN);
  assign mode     = set_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_s <= 1'b0;
      mode_p <= 1'b0;
      adv_s  <= 1'b0;
      adv_p  <= 1'b0;
      snz_s  <= 1'b0;
      snz_p  <= 1'b0;
      am_p   <= 1'b0;
    end else begin
      mode_s <= mode_btn;
      mode_p <= mode_s;
      adv_s  <= adv_btn;
      adv_p  <= adv_s;
      snz_s  <= snooze_btn;
      snz_p  <= snz_s;
      am_p   <= alarm_match;
    end
  end

  always_comb begin
    set_d  = set_q;
    adv_go = 1'b0;
    if (mode_ev) begin
      case (set_q)
        RUN:      set_d = SET_TMIN;
        SET_TMIN: set_d = SET_THRS;
        SET_THRS: set_d = SET_DAY;
        SET_DAY:  set_d = SET_AMIN;
        SET_AMIN: set_d = SET_AHRS;
        default:  set_d = RUN;
      endcase
    end else if (in_set && !activity && idle_cnt == IDLE_LAST) begin
      set_d = RUN;
    end
    // hold_cnt is non-zero only while armed by an accepted adv event
    if (adv_ev) begin
      adv_go = 1'b1;
    end else if (adv_s && hold_cnt != '0) begin
      if (!rpt_on && hold_cnt == HOLD_V) adv_go = 1'b1;
      else if (rpt_on && rpt_cnt >= REPEAT_V) adv_go = 1'b1;
    end
  end

  assign fire = adv_go & in_set & ~mode_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      set_q    <= RUN;
      timeset  <= 1'b0;
      alarmset <= 1'b0;
      min_adv  <= 1'b0;
      hrs_adv  <= 1'b0;
      day_adv  <= 1'b0;
      idle_cnt <= '0;
      hold_cnt <= '0;
      rpt_cnt  <= '0;
      rpt_on   <= 1'b0;
    end else begin
      set_q    <= set_d;
      timeset  <= (set_d == SET_TMIN) || (set_d == SET_THRS) || (set_d == SET_DAY);
      alarmset <= (set_d == SET_AMIN) || (set_d == SET_AHRS);
      min_adv  <= fire && (set_q == SET_TMIN || set_q == SET_AMIN);
      hrs_adv  <= fire && (set_q == SET_THRS || set_q == SET_AHRS);
      day_adv  <= fire && (set_q == SET_DAY);

      if (!in_set || activity) idle_cnt <= '0;
      else if (idle_cnt != IDLE_LAST) idle_cnt <= idle_cnt + IW'(1);

      if (!adv_s || mode_ev) begin
        hold_cnt <= '0;
        rpt_cnt  <= '0;
        rpt_on   <= 1'b0;
      end else if (adv_ev) begin
        hold_cnt <= in_set ? HW'(1) : '0;
        rpt_cnt  <= '0;
        rpt_on   <= 1'b0;
      end else if (hold_cnt != '0) begin
        if (hold_cnt != HOLD_V) hold_cnt <= hold_cnt + HW'(1);
        if (!rpt_on && hold_cnt == HOLD_V) begin
          rpt_on  <= 1'b1;
          rpt_cnt <= RW'(1);
        end else if (rpt_on) begin
          rpt_cnt <= (rpt_cnt >= REPEAT_V) ? RW'(1) : rpt_cnt + RW'(1);
        end
      end
    end
  end

  always_comb begin
    ring_d   = ring_q;
    tmr_load = 1'b0;
`ifdef CLOCK_SET_SNOOZE_EN
    snz_clr  = 1'b0;
    snz_inc  = 1'b0;
`endif
    if (!alarm_on) begin
      ring_d = IDLE;
    end else begin
      case (ring_q)
        IDLE: begin
          if (am_edge && set_q == RUN) begin
            ring_d   = RING;
            tmr_load = 1'b1;
`ifdef CLOCK_SET_SNOOZE_EN
            snz_clr  = 1'b1;
`endif
          end
        end
        RING: begin
          if (snz_ev) begin
`ifdef CLOCK_SET_SNOOZE_EN
            if (snz_cnt < MAX_SNZ_V) begin
              ring_d   = SNOOZE;
              tmr_load = 1'b1;
              snz_inc  = 1'b1;
            end else begin
              ring_d = IDLE;
            end
`else
            ring_d = IDLE;
`endif
          end else if (tmr == RING_LAST) begin
            ring_d = IDLE;
          end
        end
`ifdef CLOCK_SET_SNOOZE_EN
        SNOOZE: begin
          if (tmr == SNZ_LAST) begin
            ring_d   = RING;
            tmr_load = 1'b1;
          end
        end
`endif
        default: ring_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q <= IDLE;
      buzz   <= 1'b0;
      tmr    <= '0;
    end else begin
      ring_q <= ring_d;
      buzz   <= (ring_d == RING);
      if (tmr_load || ring_q == IDLE) tmr <= '0;
      else if (tmr != TSAT) tmr <= tmr + TW'(1);
    end
  end

`ifdef CLOCK_SET_SNOOZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) snz_cnt <= '0;
    else if (snz_clr) snz_cnt <= '0;
    else if (snz_inc) snz_cnt <= snz_cnt + SW'(1);
  end
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: mode sequencing, advance pulses, timeout, ring/snooze and async reset.
module tb_clock_set_ctrl;
  logic       clk, rst, mode_btn, adv_btn, snooze_btn, alarm_on, alarm_match;
  logic       timeset, alarmset, min_adv, hrs_adv, day_adv, buzz;
  logic [2:0] mode;
  int total = 0;
  int bad = 0;

  clock_set_ctrl dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .adv_btn(adv_btn),
    .snooze_btn(snooze_btn), .alarm_on(alarm_on), .alarm_match(alarm_match),
    .timeset(timeset), .alarmset(alarmset), .min_adv(min_adv), .hrs_adv(hrs_adv),
    .day_adv(day_adv), .buzz(buzz), .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mode_btn = 1'b0; adv_btn = 1'b0; snooze_btn = 1'b0; alarm_match = 1'b0; alarm_on = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic press_mode();
    mode_btn = 1'b1; tick();
    mode_btn = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode_btn = 1'b0; adv_btn = 1'b0; snooze_btn = 1'b0; alarm_match = 1'b0; alarm_on = 1'b0;
    tick(); tick();
    total++;
    if ({mode, timeset, alarmset, min_adv, hrs_adv, day_adv, buzz} !== 9'd0) begin
      bad++; $display("FAIL reset_outputs got=%b exp=0", {mode, timeset, alarmset, min_adv, hrs_adv, day_adv, buzz});
    end
    rst = 1'b0;
    tick(); tick();
    total++;
    if ({mode, timeset, alarmset, min_adv, hrs_adv, day_adv, buzz} !== 9'd0) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=0", {mode, timeset, alarmset, min_adv, hrs_adv, day_adv, buzz});
    end
  endtask

  task automatic test_mode_seq();
    logic [2:0] em;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      press_mode();
      em = 3'((i + 1) % 6);
      total++;
      if (mode !== em || timeset !== (em >= 3'd1 && em <= 3'd3) || alarmset !== (em >= 3'd4)) begin
        bad++; $display("FAIL mode_seq[%0d] got mode=%0d ts=%b as=%b exp mode=%0d", i, mode, timeset, alarmset, em);
      end
    end
  endtask

  task automatic test_adv_tap_hold();
    int nmin, nother, nmulti;
    do_reset();
    press_mode();
    nmin = 0; nother = 0;
    adv_btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      adv_btn = 1'b0;
      nmin += int'(min_adv);
      nother += int'(hrs_adv) + int'(day_adv);
    end
    total++;
    if (nmin != 1 || nother != 0) begin
      bad++; $display("FAIL adv_tap got min=%0d other=%0d exp min=1 other=0", nmin, nother);
    end
    nmin = 0; nmulti = 0;
    adv_btn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (i == 5) adv_btn = 1'b0;
      nmin += int'(min_adv);
      if (int'(min_adv) + int'(hrs_adv) + int'(day_adv) > 1) nmulti++;
    end
    total++;
    if (nmin != 5) begin
      bad++; $display("FAIL adv_hold got=%0d exp=5", nmin);
    end
    total++;
    if (nmulti != 0) begin
      bad++; $display("FAIL adv_onehot got=%0d exp=0", nmulti);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    press_mode(); press_mode(); press_mode();
    repeat (29) tick();
    total++;
    if (mode !== 3'd3) begin
      bad++; $display("FAIL timeout_before got=%0d exp=3", mode);
    end
    tick();
    total++;
    if (mode !== 3'd0 || timeset !== 1'b0) begin
      bad++; $display("FAIL timeout_fire got mode=%0d ts=%b exp mode=0 ts=0", mode, timeset);
    end
    do_reset();
    press_mode(); press_mode(); press_mode();
    repeat (28) tick();
    adv_btn = 1'b1;
    tick();
    adv_btn = 1'b0;
    tick();
    total++;
    if (mode !== 3'd3 || timeset !== 1'b1) begin
      bad++; $display("FAIL timeout_cleared got mode=%0d ts=%b exp mode=3 ts=1", mode, timeset);
    end
    total++;
    if (day_adv !== 1'b1 || min_adv !== 1'b0) begin
      bad++; $display("FAIL day_adv_pulse got day=%b min=%b exp day=1 min=0", day_adv, min_adv);
    end
  endtask

  task automatic test_ring();
    int n;
    do_reset();
    alarm_on = 1'b1;
    alarm_match = 1'b1;
    tick();
    total++;
    if (buzz !== 1'b1) begin
      bad++; $display("FAIL ring_rise got=%b exp=1", buzz);
    end
    n = int'(buzz);
    for (int i = 0; i < 69; i++) begin
      tick();
      n += int'(buzz);
    end
    total++;
    if (n != 60 || buzz !== 1'b0) begin
      bad++; $display("FAIL ring_length got=%0d end=%b exp=60 end=0", n, buzz);
    end
    alarm_match = 1'b0; tick();
    alarm_match = 1'b1;
    repeat (10) tick();
    total++;
    if (buzz !== 1'b1) begin
      bad++; $display("FAIL ring_again got=%b exp=1", buzz);
    end
    alarm_on = 1'b0;
    tick();
    total++;
    if (buzz !== 1'b0) begin
      bad++; $display("FAIL alarm_off_stop got=%b exp=0", buzz);
    end
    do_reset();
    alarm_on = 1'b1;
    press_mode();
    alarm_match = 1'b1;
    tick(); tick();
    total++;
    if (buzz !== 1'b0) begin
      bad++; $display("FAIL ring_blocked_in_set got=%b exp=0", buzz);
    end
  endtask

  task automatic test_snooze();
    do_reset();
    alarm_on = 1'b1;
    alarm_match = 1'b1;
    tick(); tick(); tick();
`ifdef CLOCK_SET_SNOOZE_EN
    for (int r = 0; r < 4; r++) begin
      snooze_btn = 1'b1; tick();
      snooze_btn = 1'b0; tick();
      total++;
      if (buzz !== 1'b0) begin
        bad++; $display("FAIL snooze_stop[%0d] got=%b exp=0", r, buzz);
      end
      if (r < 3) begin
        repeat (299) tick();
        total++;
        if (buzz !== 1'b0) begin
          bad++; $display("FAIL snooze_quiet[%0d] got=%b exp=0", r, buzz);
        end
        tick();
        total++;
        if (buzz !== 1'b1) begin
          bad++; $display("FAIL snooze_rering[%0d] got=%b exp=1", r, buzz);
        end
      end else begin
        repeat (310) tick();
        total++;
        if (buzz !== 1'b0) begin
          bad++; $display("FAIL snooze_limit got=%b exp=0", buzz);
        end
      end
    end
`else
    snooze_btn = 1'b1; tick();
    snooze_btn = 1'b0; tick();
    total++;
    if (buzz !== 1'b0) begin
      bad++; $display("FAIL snooze_stop got=%b exp=0", buzz);
    end
    repeat (5) tick();
    total++;
    if (buzz !== 1'b0) begin
      bad++; $display("FAIL snooze_stays_idle got=%b exp=0", buzz);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    press_mode();
    adv_btn = 1'b1;
    repeat (5) tick();
    total++;
    if (min_adv !== 1'b1) begin
      bad++; $display("FAIL repeat_active got=%b exp=1", min_adv);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({mode, timeset, alarmset, min_adv, hrs_adv, day_adv, buzz} !== 9'd0) begin
      bad++; $display("FAIL async_reset_set got=%b exp=0", {mode, timeset, alarmset, min_adv, hrs_adv, day_adv, buzz});
    end
    adv_btn = 1'b0;
    tick();
    rst = 1'b0;
    alarm_on = 1'b1;
    alarm_match = 1'b1;
    tick(); tick();
    total++;
    if (buzz !== 1'b1) begin
      bad++; $display("FAIL ring_before_reset got=%b exp=1", buzz);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (buzz !== 1'b0 || mode !== 3'd0) begin
      bad++; $display("FAIL async_reset_ring got buzz=%b mode=%0d exp 0/0", buzz, mode);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int np, nh, nm;
    do_reset();
    press_mode();
    mode_btn = 1'b1; adv_btn = 1'b1;
    np = 0;
    tick();
    mode_btn = 1'b0; adv_btn = 1'b0;
    np += int'(min_adv) + int'(hrs_adv) + int'(day_adv);
    tick();
    total++;
    if (mode !== 3'd2) begin
      bad++; $display("FAIL simul_mode got=%0d exp=2", mode);
    end
    for (int i = 0; i < 6; i++) begin
      np += int'(min_adv) + int'(hrs_adv) + int'(day_adv);
      tick();
    end
    total++;
    if (np != 0) begin
      bad++; $display("FAIL simul_no_adv got=%0d exp=0", np);
    end
    nh = 0; nm = 0;
    adv_btn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      adv_btn = 1'b0;
      nh += int'(hrs_adv);
      nm += int'(min_adv) + int'(day_adv);
    end
    total++;
    if (nh != 1 || nm != 0) begin
      bad++; $display("FAIL hrs_tap got hrs=%0d other=%0d exp hrs=1 other=0", nh, nm);
    end
  endtask

  initial begin
    test_reset();
    test_mode_seq();
    test_adv_tap_hold();
    test_timeout();
    test_ring();
    test_snooze();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
